// File: rtl/ble_cmd_pkg.sv
// Shared state types and constants for the BLE command responder.
package ble_cmd_pkg;

   typedef enum logic {WAIT_HI, WAIT_LO}   cmd_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT}  tx_state_t;

   localparam logic [7:0]  RESP_ACK         = 8'hA5;
   localparam int unsigned BAUD_DIV_DEFAULT = 2604;

endpackage

// File: rtl/ble_byte_rx.sv
// RX pin synchronizer and 8N1 byte receiver with mid-bit sampling.
module ble_byte_rx
   import ble_cmd_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       rx_ferr,
   output logic       rx_start
);

   localparam int unsigned   BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] FULL_LAST = BW'(BAUD_DIV - 1);

   logic          rx_meta, rx_sync, rx_prev;
   logic          busy;
   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;

   assign rx_start = !busy && rx_prev && !rx_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_rdy   <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         rx_rdy  <= 1'b0;
         rx_ferr <= 1'b0;
         if (rx_start) begin
            busy     <= 1'b1;
            bit_cnt  <= '0;
            // the edge happened on rx_sync one clock before detection
            baud_cnt <= BW'(1);
         end else if (busy) begin
            if (baud_cnt >= ((bit_cnt == 4'd0) ? HALF_LAST : FULL_LAST)) begin
               baud_cnt <= '0;
               bit_cnt  <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) begin
                  busy <= 1'b0;
                  if (rx_sync) begin
                     rx_rdy  <= 1'b1;
                     rx_data <= shreg;
                  end else begin
                     rx_ferr <= 1'b1;
                  end
               end else if (bit_cnt != 4'd0) begin
                  shreg <= {rx_sync, shreg[7:1]};
               end
            end else begin
               baud_cnt <= baud_cnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/ble_cmd_responder.sv
// BLE command endpoint: two-byte command assembly plus one-byte response TX.
// Optional high/low byte timeout enabled by defining CMD_TIMEOUT_EN.
module ble_cmd_responder
   import ble_cmd_pkg::*;
#(
   parameter int unsigned BAUD_DIV     = BAUD_DIV_DEFAULT,
   parameter logic [19:0] TIMEOUT_CLKS = 20'd1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done,
   output logic        frame_err
);

   localparam int unsigned   BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   logic [7:0] rx_data;
   logic       rx_rdy, rx_ferr, rx_start;

   ble_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .RX       (RX),
      .rx_data  (rx_data),
      .rx_rdy   (rx_rdy),
      .rx_ferr  (rx_ferr),
      .rx_start (rx_start)
   );

   cmd_state_t cmd_state;
   logic [7:0] hi_byte;
`ifdef CMD_TIMEOUT_EN
   logic [19:0] tmo_cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_state <= WAIT_HI;
         hi_byte   <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         frame_err <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         frame_err <= rx_ferr;
         // clear is applied first so a command completing this cycle overrides it
         if (clr_cmd_rdy || (rx_start && cmd_state == WAIT_HI))
            cmd_rdy <= 1'b0;
         case (cmd_state)
            WAIT_HI: begin
               if (rx_rdy) begin
                  hi_byte   <= rx_data;
                  cmd_state <= WAIT_LO;
`ifdef CMD_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end
            end
            WAIT_LO: begin
               if (rx_rdy) begin
                  cmd       <= {hi_byte, rx_data};
                  cmd_rdy   <= 1'b1;
                  cmd_state <= WAIT_HI;
               end
`ifdef CMD_TIMEOUT_EN
               else if (tmo_cnt == TIMEOUT_CLKS - 20'd1) begin
                  frame_err <= 1'b1;
                  cmd_state <= WAIT_HI;
               end
               tmo_cnt <= tmo_cnt + 20'd1;
`endif
            end
            default: cmd_state <= WAIT_HI;
         endcase
      end
   end

   tx_state_t     tx_state;
   logic [8:0]    tx_shreg;
   logic [BW-1:0] tx_baud;
   logic [3:0]    tx_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         TX       <= 1'b1;
         tx_done  <= 1'b0;
         tx_shreg <= '1;
         tx_baud  <= '0;
         tx_bit   <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (trmt) begin
                  tx_shreg <= {1'b1, resp};
                  TX       <= 1'b0;
                  tx_done  <= 1'b0;
                  tx_baud  <= '0;
                  tx_bit   <= '0;
                  tx_state <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               if (tx_baud == BAUD_LAST) begin
                  tx_baud <= '0;
                  tx_bit  <= tx_bit + 4'd1;
                  if (tx_bit == 4'd9) begin
                     TX       <= 1'b1;
                     tx_done  <= 1'b1;
                     tx_state <= TX_IDLE;
                  end else begin
                     TX       <= tx_shreg[0];
                     tx_shreg <= {1'b1, tx_shreg[8:1]};
                  end
               end else begin
                  tx_baud <= tx_baud + BW'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ble_cmd_responder.md
# ble_cmd_responder

Device-side endpoint of the BLE command link. It deserializes the two-byte, high-byte-first UART command stream sent by the remote into a 16-bit `cmd`, and holds that command for the command processor. It also serializes the one-byte status response (e.g. 8'hA5 = command complete) back to the remote. It sits between the `RX`/`TX` pins of the top level and the command processor, and is the counterpart of the remote-side command sender.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud).
- `TIMEOUT_CLKS`, default 20'd1_000_000: max clocks between high and low byte. Used only with `CMD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `RX`  in  1  serial input from BLE module; idle high; asynchronous to `clk`.
- `TX`  out  1  serial output to BLE module; idle high.
- `cmd`  out  16  assembled command, `{high_byte, low_byte}`.
- `cmd_rdy`  out  1  `cmd` valid; held until cleared.
- `clr_cmd_rdy`  in  1  consumer acknowledges `cmd`.
- `resp`  in  8  response byte; sampled on `trmt`.
- `trmt`  in  1  one-cycle request to send `resp`.
- `tx_done`  out  1  last response fully shifted out.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled 0, or a timeout occurred.

## Operation
- **RX synchronizer:** double-flop, both flops reset to 1.
- **Byte receiver:**
  - Start is a falling edge on the synchronized RX while idle.
  - Bits are sampled at mid-bit: first sample at `BAUD_DIV/2` after the edge, then every `BAUD_DIV`.
  - Frame is 1 start + 8 data bits (LSB first) + 1 stop.
  - Stop bit = 0: byte discarded, `frame_err` pulses, command FSM unchanged.
- **Command FSM states:** `WAIT_HI`, `WAIT_LO`.
  - `WAIT_HI`: a good byte is latched into the high register -> `WAIT_LO`.
  - `WAIT_LO`: a good byte updates `cmd <= {hi, byte}`, sets `cmd_rdy` -> `WAIT_HI`.
- **`cmd_rdy` clear:** cleared by `clr_cmd_rdy`, or by a start-bit detection while in `WAIT_HI`.
- **`cmd` stability:** `cmd` changes only when `cmd_rdy` is set.
- **Simultaneous set and clear of `cmd_rdy`:** set wins.
- **Transmitter states:** `TX_IDLE`, `TX_SHIFT`.
  - `trmt` in `TX_IDLE` loads `{1'b1, resp, 1'b0}`, clears `tx_done`, shifts LSB first, each bit held `BAUD_DIV` clocks.
  - After the stop bit completes: `tx_done` set -> `TX_IDLE`.
  - `trmt` while in `TX_SHIFT` is ignored.
- **Full duplex:** RX and TX are independent.

## Timing
- **Reset values:** `TX`=1, `cmd`=0, `cmd_rdy`=0, `tx_done`=0, `frame_err`=0; FSMs in `WAIT_HI` / `TX_IDLE`.
- **Reset mid-frame:** both FSMs abort; the partial byte and high byte are lost. `TX` is forced to 1 on the next edge.
- **Command latency:** `cmd_rdy` rises 1 clock after the stop-bit sample of the low byte, i.e. about 2 + 9.5·`BAUD_DIV` + 1 clocks after the low byte's start edge on the pin.
- **TX latency:** `TX` goes low the clock after `trmt`. The frame lasts exactly 10·`BAUD_DIV` clocks. `tx_done` rises on the clock the stop bit ends.
- **Baud counter width:** `$clog2(BAUD_DIV)` bits. Bit counter is 4 bits and counts to 10; no wrap.

## Configuration
- **`CMD_TIMEOUT_EN` defined:**
  - A counter runs in `WAIT_LO`.
  - Reaching `TIMEOUT_CLKS` before the low byte completes: drop the high byte, pulse `frame_err`, return to `WAIT_HI`.
  - A low byte completing on the timeout cycle is accepted (byte wins).
- **Not defined:** no counter; `WAIT_LO` waits indefinitely.

## Structure
- **Package `ble_cmd_pkg`:**
  - `cmd_state_t` (`WAIT_HI`, `WAIT_LO`) and `tx_state_t` (`TX_IDLE`, `TX_SHIFT`).
  - `RESP_ACK` = 8'hA5.
  - Default baud divisor constant.
- **Sub-module `ble_byte_rx`:** synchronizer + byte receiver; outputs `rx_data[7:0]`, a one-cycle `rx_rdy`, and `rx_ferr`. The top level holds the command FSM, transmitter, and optional timeout.

## Test plan
- **Reset:** `rst_n` low 2 clocks mid-TX -> next clock `TX`=1, `tx_done`=0, `cmd_rdy`=0.
- **Command assembly:** remote sends bytes 8'h40, 8'h01 -> `cmd`=16'h4001, `cmd_rdy`=1 one clock after the second stop-bit sample. `clr_cmd_rdy` pulse -> `cmd_rdy`=0, `cmd` unchanged.
- **Response:** `trmt` with `resp`=8'hA5 -> `TX` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit `BAUD_DIV` clocks. `tx_done`=1 after 10·`BAUD_DIV` clocks. A second `trmt` during the shift is ignored.
- **Framing error:** high byte 8'h20 with stop bit forced 0 -> `frame_err` pulse, FSM stays `WAIT_HI`. Then 8'h20, 8'h00 -> `cmd`=16'h2000.
- **Ack collision:** `clr_cmd_rdy` on the same clock a new command completes -> `cmd_rdy` stays 1 with the new value.
- **Timeout (with `CMD_TIMEOUT_EN`, `TIMEOUT_CLKS`=50000):** send 8'h12, idle 60000 clocks, then 8'h34, 8'h56 -> one `frame_err` pulse, `cmd`=16'h3456.
